// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the iterative multiply/divide unit.
//   muldiv_op_e    - operation encoding on the op port
//   muldiv_state_e - control FSM states
//   is_signed_op() - true when src_a is interpreted as two's complement
//   is_div_op()    - true for the DIV/DIVU/REM/REMU family
//   is_rem_op()    - true when the remainder is the returned result
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  // MUL only uses the low half, so signed or unsigned treatment gives the
  // same bits; it is grouped with the signed ops for uniformity.
  function automatic logic is_signed_op(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_div_op(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem_op(muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// muldiv_divstep: one combinational restoring-division step.
//   rem_in   - partial remainder (always < divisor)
//   quo_in   - remaining dividend bits shifted in from the MSB, quotient
//              bits collected at the LSB
//   divisor  - divisor magnitude
//   rem_out  - updated partial remainder
//   quo_out  - quo_in shifted left with the new quotient bit in bit 0
module muldiv_divstep
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_in,
  input  logic [DATA_WIDTH-1:0] quo_in,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_out,
  output logic [DATA_WIDTH-1:0] quo_out
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    // Since rem_in < divisor, shifted < 2*divisor: the MSB of the
    // difference is a clean borrow flag.
    if (diff[DATA_WIDTH]) begin
      rem_out = shifted[DATA_WIDTH-1:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[DATA_WIDTH-1:0];
      quo_out = {quo_in[DATA_WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit (RISC-V M op set).
//   clk, rst_n           - clock, asynchronous active-low reset
//   flush                - synchronous kill of any in-flight operation
//   in_valid/in_ready    - request handshake (op, src_a, src_b)
//   out_valid/out_ready  - result handshake (result, zero)
//   busy                 - high whenever the unit is not idle
// Build option MULDIV_FAST_MUL_EN: multiplies complete through a registered
// single-cycle multiplier instead of the shift-add loop.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// BUSY    | one shift-add / shift-subtract step per cycle
// DONE    | result held on the output until out_ready
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int OPCODE_LENGTH = 3,
  localparam int CNT_WIDTH     = $clog2(DATA_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPCODE_LENGTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]    src_a,
  input  logic [DATA_WIDTH-1:0]    src_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     zero,
  output logic                     busy
);

  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e           state_q;
  muldiv_op_e              op_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic [W-1:0]            mcand_q;
  logic [2*W-1:0]          prod_q;
  logic [W-1:0]            rem_q;
  logic [W-1:0]            quo_q;
  logic [W-1:0]            divisor_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic [W-1:0]            result_q;
  logic                    zero_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    busy_q;

  // Accept-stage decode
  muldiv_op_e              op_in;
  logic                    a_sgn;
  logic                    b_sgn;
  logic [W-1:0]            a_mag;
  logic [W-1:0]            b_mag;
  logic                    special;
  logic [W-1:0]            special_res;

  always_comb begin
    op_in = muldiv_op_e'(op);
    a_sgn = is_signed_op(op_in) & src_a[W-1];
    b_sgn = is_signed_op(op_in) & (op_in != OP_MULHSU) & src_b[W-1];
    a_mag = a_sgn ? -src_a : src_a;
    b_mag = b_sgn ? -src_b : src_b;

    special     = 1'b0;
    special_res = '0;
    if (is_div_op(op_in)) begin
      if (src_b == '0) begin
        special     = 1'b1;
        special_res = is_rem_op(op_in) ? src_a : '1;
      end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (src_a == MOST_NEG) && (src_b == '1)) begin
        special     = 1'b1;
        special_res = is_rem_op(op_in) ? '0 : src_a;
      end
    end else if ((src_a == '0) || (src_b == '0)) begin
      special     = 1'b1;
      special_res = '0;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [W:0]     fast_a;
  logic signed [W:0]     fast_b;
  logic signed [2*W+1:0] fast_full;
  logic [W-1:0]          fast_res;

  // Operands widened by one bit so MULHSU/MULHU share the signed multiplier.
  always_comb begin
    fast_a    = {a_sgn, src_a};
    fast_b    = {b_sgn, src_b};
    fast_full = fast_a * fast_b;
    fast_res  = (op_in == OP_MUL) ? fast_full[W-1:0] : fast_full[2*W-1:W];
  end
`endif

  // Iteration datapath
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod_nxt;
  logic [2*W-1:0] prod_fin;
  logic [W-1:0]   rem_nxt;
  logic [W-1:0]   quo_nxt;
  logic [W-1:0]   final_res;

  muldiv_divstep #(.DATA_WIDTH(W)) u_divstep (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (divisor_q),
    .rem_out (rem_nxt),
    .quo_out (quo_nxt)
  );

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[W-1:1]};
    prod_fin = neg_res_q ? -prod_nxt : prod_nxt;
    case (op_q)
      OP_MUL:                     final_res = prod_fin[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fin[2*W-1:W];
      OP_DIV, OP_DIVU:            final_res = neg_res_q ? -quo_nxt : quo_nxt;
      default:                    final_res = neg_rem_q ? -rem_nxt : rem_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_q   <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_q       <= op_in;
            neg_res_q  <= a_sgn ^ b_sgn;
            neg_rem_q  <= a_sgn;
            mcand_q    <= a_mag;
            prod_q     <= {{W{1'b0}}, b_mag};
            rem_q      <= '0;
            quo_q      <= a_mag;
            divisor_q  <= b_mag;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (special) begin
              state_q     <= ST_DONE;
              result_q    <= special_res;
              zero_q      <= (special_res == '0);
              out_valid_q <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div_op(op_in)) begin
              state_q     <= ST_DONE;
              result_q    <= fast_res;
              zero_q      <= (fast_res == '0);
              out_valid_q <= 1'b1;
`endif
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          prod_q <= prod_nxt;
          rem_q  <= rem_nxt;
          quo_q  <= quo_nxt;
          cnt_q  <= cnt_q + CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(W - 1)) begin
            state_q     <= ST_DONE;
            result_q    <= final_res;
            zero_q      <= (final_res == '0);
            out_valid_q <= 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a
// 64-bit arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          p;
    longint unsigned up;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = sa * sb;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub;          return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(logic [2:0] o, logic [31:0] a, logic [31:0] b);
    if (o[2]) begin
      if (b == 0) return 1;
      if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (a == 0 || b == 0) return 1;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'd1;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  // Issue one request, check latency/result/zero, optionally hold the
  // result under backpressure for 'hold' cycles, then retire it.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_r;
    int          lat;
    exp_r = ref_res(o, a, b);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid  = 1'b1;
    op        = o;
    src_a     = a;
    src_b     = b;
    out_ready = (hold == 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
    chk({tag, "_latency"}, lat, ref_lat(o, a, b));
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_zero"}, zero, exp_r == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_result"}, result, exp_r);
      chk({tag, "_hold_busy"}, {out_valid, in_ready}, 2'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_retired"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    bit          seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    #12;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, zero, busy, result}, {4'b1000, 32'd0});
    rst_n = 1'b1;

    // Directed multiplies
    run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 0);
    run_op("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 0);
    run_op("mulhu_ones",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run_op("mulhsu_m1",    3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0);
    run_op("mul_zero",     3'd0, 32'd0,          32'd1234,      0);

    // Directed divides
    run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         0);
    run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         0);
    run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         0);

    // Special cases
    run_op("divu_by0",     3'd5, 32'd5,          32'd0,         0);
    run_op("remu_by0",     3'd7, 32'd5,          32'd0,         0);
    run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0);
    run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0);

    // Backpressure on an iterative and a special-case result
    run_op("bp_divu",      3'd5, 32'd1000,       32'd3,         10);
    run_op("bp_div0",      3'd4, 32'd77,         32'd0,         3);

    // Flush at BUSY cycle 5 with a request presented in the same cycle
    @(negedge clk);
    in_valid = 1'b1; op = 3'd5; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", {out_valid, in_ready, busy}, 3'b010);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", seen, 1'b0);

    // Flush in IDLE wins over a simultaneous request
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; src_a = 32'd9; src_b = 32'd3;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_blocks_accept", {busy, in_ready}, 2'b01);

    // Reset pulse mid-BUSY
    @(negedge clk);
    in_valid = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'hFFFF_FFFD;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("reset_abort", {in_ready, out_valid, zero, busy, result}, {4'b1000, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("reset_no_valid", seen, 1'b0);
    run_op("divu_9_3", 3'd5, 32'd9, 32'd3, 0);

    // Randomized operations
    for (int n = 0; n < 60; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op("rand", ro, ra, rb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
